rocketcpu_gpio_arbiter: RTL
===========================

// Module: rocketcpu_gpio_arbiter
// PURPOSE
//  Shares the single-port GPIO Wishbone slave between two Wishbone masters (m0 = CPU data bus, m1 = secondary master).
//  Round-robin arbitration; one access in flight; ack generated here because the GPIO slave has no ack.
//  Sits between the CPU peripheral decoder and the GPIO slave. Slave read data is registered with one cycle of latency.
// PARAMETERS
//  RESET_PRIO  0   master that wins the first simultaneous request after reset (0 or 1)
//  LOCK_MAX    16  max consecutive locked accesses before forced release (only with ROCKETCPU_GPIO_ARB_LOCK_EN)
// PORTS
//  i_wb_clk    in   1   clock
//  i_wb_rst_n  in   1   reset, synchronous, active-low
//  i_m0_cyc    in   1   m0 request; held until o_m0_ack
//  i_m0_we     in   1   m0 write enable
//  i_m0_dat    in   32  m0 write data
//  i_m0_lock   in   1   m0 bus-lock request (used only with the macro)
//  o_m0_ack    out  1   m0 access complete, 1-cycle pulse
//  o_m0_rdt    out  32  m0 read data; valid while o_m0_ack, else 0
//  i_m1_*/o_m1_*        same set for m1
//  o_s_cyc     out  1   slave strobe
//  o_s_we      out  1   slave write enable
//  o_s_dat     out  32  slave write data
//  i_s_rdt     in   32  slave read data (registered in slave)
//  o_grant     out  2   one-hot current owner; 00 when idle
//  o_busy      out  1   state != IDLE
// BEHAVIOUR
//  - Reset (i_wb_rst_n=0 at an edge): state=IDLE, o_grant=00, o_s_cyc/we/dat=0, acks=0, pointer so RESET_PRIO wins next, lock cleared.
//  - FSM: IDLE -> ACCESS -> ACK -> IDLE; every access takes exactly 3 cycles from request sampled to ack.
//  - IDLE: sample i_m0_cyc/i_m1_cyc. One request: grant it. Both: grant the master not granted last (pointer). None: stay.
//    On grant: register o_grant and latch the winner's we/dat into o_s_we/o_s_dat; o_s_cyc=1 next cycle; pointer <= winner.
//  - ACCESS: o_s_cyc=1 for exactly one cycle; the slave writes/samples at the closing edge; o_s_cyc=0 on entry to ACK.
//  - ACK: o_mX_ack=1 for the owner only; o_mX_rdt=i_s_rdt for the owner, 0 for the other.
//    o_grant is cleared on exit to IDLE.
//  - Masters drop cyc in the cycle after ack. A master that keeps cyc high is treated as a new request.
//  - Non-owner request during ACCESS/ACK: ignored, not lost; served at the next IDLE if cyc is still high.
//  - A master dropping cyc mid-access: the access still completes and ack is still pulsed (no abort).
//  - Reset mid-access: access abandoned, no ack, o_s_cyc=0 after the reset edge; the slave may already have committed a write.
//  - Never two acks in one cycle; never o_s_cyc without a one-hot o_grant.
// CONFIGURATION
//  ROCKETCPU_GPIO_ARB_LOCK_EN defined:
//    - Owner's i_mX_lock=1 during ACK sets locked. While locked, IDLE considers only the owner's cyc; the other master waits.
//    - A 5-bit counter counts locked accesses. Lock is released when the owner's lock=0 in ACK or count reaches LOCK_MAX.
//    - On forced release the pointer favours the other master; the counter clears on release and on reset.
//  Not defined: i_m*_lock ignored, no lock state or counter; pure round-robin.
// TESTING
//  1 rst_n=0 for 3 cycles with both cyc=1 -> all outputs 0, o_busy=0; first grant after release = RESET_PRIO.
//  2 m0 alone: cyc=1, we=1, dat=0x1 at t0 -> o_s_cyc=1, we=1, dat=0x1 at t1; o_m0_ack=1 at t2; o_grant=01 at t1-t2.
//  3 m0 and m1 cyc=1 together, RESET_PRIO=0, held -> grants 01,10,01,10; each ack 3 cycles apart.
//  4 m1 read, i_s_rdt=0x00000002 in ACK -> o_m1_rdt=0x2 with o_m1_ack; o_m0_rdt=0, o_m0_ack=0.
//  5 rst_n=0 at the edge ending ACCESS -> no ack in any later cycle, o_s_cyc=0, o_grant=00, IDLE.
//  6 LOCK_EN, LOCK_MAX=4, m1 lock=1, both cyc held -> m1 acked 4 times in a row, then m0 granted.

Source files
------------

// File: rtl/rocketcpu_gpio_arbiter.sv
// ----------------------------------------------------------------------------
// rocketcpu_gpio_arbiter
//
// Shares the single-port GPIO Wishbone slave between two masters
// (m0 = CPU data bus, m1 = secondary master). Round-robin arbitration with
// one access in flight. The GPIO slave has no ack, so the ack comes from here.
//
// Every access runs IDLE -> ACCESS -> ACK -> IDLE:
//   cycle t0 (IDLE)   : request sampled at the closing edge, winner latched
//   cycle t1 (ACCESS) : o_s_cyc=1, slave writes/samples at the closing edge
//   cycle t2 (ACK)    : owner's ack pulses, owner's rdt = i_s_rdt
//
// Parameters
//   RESET_PRIO  master that wins the first simultaneous request after reset
//   LOCK_MAX    locked accesses allowed back-to-back before forced release
//
// Optional feature (compile-time macro ROCKETCPU_GPIO_ARB_LOCK_EN)
//   Bus lock. While the owner asserts its lock input during ACK, the next
//   IDLE considers only that owner's request, up to LOCK_MAX accesses in a
//   row. Without the macro the lock inputs are ignored.
//
// Ports
//   i_wb_clk, i_wb_rst_n        clock, synchronous active-low reset
//   i_mX_cyc/we/dat/lock        master X request, write enable, data, lock
//   o_mX_ack, o_mX_rdt          master X ack pulse, read data (0 when no ack)
//   o_s_cyc/we/dat, i_s_rdt     slave strobe, write enable, data, read data
//   o_grant                     one-hot owner, 00 when idle
//   o_busy                      arbiter not idle
// ----------------------------------------------------------------------------
module rocketcpu_gpio_arbiter #(
    parameter int RESET_PRIO = 0,
    parameter int LOCK_MAX   = 16
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst_n,

    input  logic        i_m0_cyc,
    input  logic        i_m0_we,
    input  logic [31:0] i_m0_dat,
    input  logic        i_m0_lock,
    output logic        o_m0_ack,
    output logic [31:0] o_m0_rdt,

    input  logic        i_m1_cyc,
    input  logic        i_m1_we,
    input  logic [31:0] i_m1_dat,
    input  logic        i_m1_lock,
    output logic        o_m1_ack,
    output logic [31:0] o_m1_rdt,

    output logic        o_s_cyc,
    output logic        o_s_we,
    output logic [31:0] o_s_dat,
    input  logic [31:0] i_s_rdt,

    output logic [1:0]  o_grant,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    // Request as seen by the slave, latched at grant time.
    typedef struct packed {
        logic        we;
        logic [31:0] dat;
    } s_req_t;

    // The pointer stores who was granted last; the other master wins a tie.
    // Resetting it to the non-preferred master lets RESET_PRIO win first.
    localparam logic RST_LAST_M1 = (RESET_PRIO == 0);

    // 6 bits so the count+1 comparison cannot wrap for any 5-bit count.
    localparam logic [5:0] LOCK_LIMIT = 6'(LOCK_MAX);

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       last_m1_q, last_m1_d;
    logic       s_cyc_q, s_cyc_d;
    s_req_t     s_req_q, s_req_d;

    logic [1:0] req_vec;
    logic       win_m1;

`ifdef ROCKETCPU_GPIO_ARB_LOCK_EN
    logic       locked_q, locked_d;
    logic [4:0] lock_cnt_q, lock_cnt_d;
    logic       owner_lock;

    assign owner_lock = grant_q[1] ? i_m1_lock : i_m0_lock;
`else
    logic unused_lock;
    assign unused_lock = ^{i_m0_lock, i_m1_lock, LOCK_LIMIT};
`endif

    // ------------------------------------------------------------------
    // Request qualification and round-robin pick
    // ------------------------------------------------------------------
    always_comb begin
        req_vec = {i_m1_cyc, i_m0_cyc};
`ifdef ROCKETCPU_GPIO_ARB_LOCK_EN
        // While locked the last winner is still the lock owner; the other
        // master's request is masked and simply waits.
        if (locked_q) begin
            req_vec = last_m1_q ? {i_m1_cyc, 1'b0} : {1'b0, i_m0_cyc};
        end
`endif
        // m1 wins when it is alone, or when both ask and m0 went last.
        win_m1 = req_vec[1] & (~req_vec[0] | ~last_m1_q);
    end

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_m1_d = last_m1_q;
        s_cyc_d   = 1'b0;
        s_req_d   = s_req_q;
`ifdef ROCKETCPU_GPIO_ARB_LOCK_EN
        locked_d   = locked_q;
        lock_cnt_d = lock_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (|req_vec) begin
                    state_d   = ST_ACCESS;
                    grant_d   = win_m1 ? 2'b10 : 2'b01;
                    last_m1_d = win_m1;
                    s_cyc_d   = 1'b1;
                    if (win_m1) begin
                        s_req_d.we  = i_m1_we;
                        s_req_d.dat = i_m1_dat;
                    end else begin
                        s_req_d.we  = i_m0_we;
                        s_req_d.dat = i_m0_dat;
                    end
                end
            end

            // Strobe is high for exactly this one cycle; it drops at the
            // closing edge because s_cyc_d defaults to 0.
            ST_ACCESS: begin
                state_d = ST_ACK;
            end

            ST_ACK: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
`ifdef ROCKETCPU_GPIO_ARB_LOCK_EN
                // The first locked access already counts, so LOCK_MAX is the
                // length of the whole uninterrupted run. On forced release the
                // pointer still names the owner, so the other master is
                // favoured at the next tie without extra logic.
                if (owner_lock) begin
                    if (({1'b0, lock_cnt_q} + 6'd1) >= LOCK_LIMIT) begin
                        locked_d   = 1'b0;
                        lock_cnt_d = 5'd0;
                    end else begin
                        locked_d   = 1'b1;
                        lock_cnt_d = lock_cnt_q + 5'd1;
                    end
                end else begin
                    locked_d   = 1'b0;
                    lock_cnt_d = 5'd0;
                end
`endif
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_wb_clk) begin
        if (!i_wb_rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= 2'b00;
            last_m1_q <= RST_LAST_M1;
            s_cyc_q   <= 1'b0;
            s_req_q   <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_m1_q <= last_m1_d;
            s_cyc_q   <= s_cyc_d;
            s_req_q   <= s_req_d;
        end
    end

`ifdef ROCKETCPU_GPIO_ARB_LOCK_EN
    always_ff @(posedge i_wb_clk) begin
        if (!i_wb_rst_n) begin
            locked_q   <= 1'b0;
            lock_cnt_q <= 5'd0;
        end else begin
            locked_q   <= locked_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Acks decode registered state only, so at most one can be high and a
    // reset edge removes them immediately.
    assign o_m0_ack = (state_q == ST_ACK) & grant_q[0];
    assign o_m1_ack = (state_q == ST_ACK) & grant_q[1];

    // Slave data is already registered inside the slave; pass it through
    // only to the master being acked.
    assign o_m0_rdt = o_m0_ack ? i_s_rdt : 32'd0;
    assign o_m1_rdt = o_m1_ack ? i_s_rdt : 32'd0;

    assign o_s_cyc = s_cyc_q;
    assign o_s_we  = s_req_q.we;
    assign o_s_dat = s_req_q.dat;
    assign o_grant = grant_q;
    assign o_busy  = (state_q != ST_IDLE);

endmodule
